spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//  SPI master driving the single-slave SPI-RAM link: serialises one command frame
//  (2-bit cmd + MEM_WIDTH payload) onto MOSI under SS_n, and for read-data commands
//  (cmd=2'b11) captures MEM_WIDTH reply bits from MISO. Sits between the system-side
//  request interface and the SPI slave/RAM wrapper; the counterpart of the SPI slave.
// PARAMETERS
//  MEM_WIDTH      8  payload/reply width; frame width = MEM_WIDTH+2
//  RD_TURNAROUND  2  cycles SS_n held low, MOSI=0, between last MOSI bit and first MISO sample
// PORTS
//  clk       in   1            system clock, all logic on posedge
//  rst_n     in   1            asynchronous, active-low reset
//  start     in   1            request; accepted only when start && ready
//  frame_in  in   MEM_WIDTH+2  frame: [MW+1:MW]=cmd (00 wr_addr,01 wr_data,10 rd_addr,11 rd_data), [MW-1:0]=payload
//  ready     out  1            high only in IDLE
//  busy      out  1            ~ready
//  done      out  1            one-cycle pulse in STOP of a completed transfer
//  rd_data   out  MEM_WIDTH    last captured reply; holds until next rd_data transfer
//  rd_valid  out  1            one-cycle pulse with done for cmd=11 only
//  SS_n      out  1            slave select, active low, registered
//  MOSI      out  1            serial out, registered, MSB first
//  MISO      in   1            serial in from slave
//  abort     in   1            only when SPI_MASTER_ABORT_EN defined
// BEHAVIOUR
//  Reset (async): state=IDLE, SS_n=1, MOSI=0, ready=1, busy=0, done=0, rd_valid=0, rd_data=0, counters=0.
//  FSM: IDLE -> START -> SHIFT -> (cmd==11 ? WAIT_RD -> RECV) -> STOP -> IDLE.
//  IDLE:    SS_n=1, MOSI=0; on start&&ready latch frame_in into frame_q, go START.
//  START:   1 cycle, SS_n=0, MOSI=0 (slave enters CHK_CMD).
//  SHIFT:   MEM_WIDTH+2 cycles; cycle i drives MOSI=frame_q[MW+1-i], SS_n=0; 4-bit bit_cnt 0..MW+1.
//  WAIT_RD: RD_TURNAROUND cycles, SS_n=0, MOSI=0; RD_TURNAROUND=0 skips directly to RECV.
//  RECV:    MEM_WIDTH cycles, SS_n=0; sample MISO each posedge, shift left into rx_shift (MSB first).
//  STOP:    1 cycle, SS_n=1, MOSI=0, done=1; if cmd==11: rd_data<=rx_shift, rd_valid=1.
//  Busy time: non-read = MW+4 cycles (12 @MW=8); SS_n low MW+3 cycles.
//             cmd=11 adds RD_TURNAROUND+MW cycles (22 total @defaults).
//  start while busy: ignored, frame_q unchanged, no queuing. start held high: next
//   transfer accepted in the IDLE cycle after STOP -> SS_n high >=2 cycles between frames.
//  frame_in sampled only at acceptance; later changes have no effect.
//  rst_n low mid-transfer: immediate return to IDLE, SS_n=1; no done/rd_valid; rd_data cleared.
//  MISO ignored outside RECV. done and rd_valid never high for more than one cycle.
// CONFIGURATION
//  SPI_MASTER_ABORT_EN defined: abort port exists; abort=1 in START/SHIFT/WAIT_RD/RECV
//   -> next state STOP with SS_n=1, done=0, rd_valid=0, rd_data unchanged; ignored in IDLE/STOP.
//  Undefined: no abort port; every accepted transfer runs to completion.
// TESTING
//  1 Reset: assert rst_n=0 during SHIFT bit 4 -> same cycle SS_n=1, MOSI=0, ready=1, no done.
//  2 Write addr: frame_in=10'b00_1010_0101 -> SS_n low 11 cycles; MOSI over SHIFT = 0,0,1,0,1,0,0,1,0,1;
//    done at cycle 12 after acceptance; rd_valid stays 0.
//  3 Read data: frame_in=10'b11_0000_0000, bench drives MISO=8'hC3 MSB first during RECV
//    -> rd_data=8'hC3, rd_valid=done=1 for one cycle, 22 busy cycles.
//  4 Start while busy: pulse start with frame_in=10'h3FF at SHIFT bit 3 -> ignored,
//    MOSI continues original frame, exactly one done.
//  5 Back-to-back: start held high, two wr_data frames -> SS_n=1 for exactly 2 cycles between frames.
//  6 (ABORT_EN) abort=1 in RECV bit 5 of cmd=11 -> SS_n=1 next cycle, done=0, rd_valid=0, rd_data unchanged.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI-RAM link master, one cmd+payload frame per request.
// Optional abort input enabled by defining SPI_MASTER_ABORT_EN.
module spi_master_ctrl #(
  parameter int MEM_WIDTH     = 8,
  parameter int RD_TURNAROUND = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MEM_WIDTH+1:0] frame_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [MEM_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 SS_n,
  output logic                 MOSI,
`ifdef SPI_MASTER_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 MISO
);

  localparam int FW = MEM_WIDTH + 2;
  localparam logic [3:0] SHIFT_LAST = 4'(FW - 1);
  localparam logic [3:0] RECV_LAST  = 4'(MEM_WIDTH - 1);
  localparam logic [3:0] WAIT_LAST  =
    (RD_TURNAROUND > 0) ? 4'(RD_TURNAROUND - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE, START, SHIFT, WAIT_RD, RECV, STOP
  } state_t;

  state_t state, next;

  logic [1:0]           cmd_q;
  logic [FW-1:0]        tx_shift;
  logic [MEM_WIDTH-2:0] rx_shift;
  logic [3:0]           bit_cnt;
  logic                 aborted;
  logic                 abort_in;
  logic                 abort_hit;
  logic                 ss_d;
  logic                 mosi_d;
  logic                 is_rd;
  logic                 active;

`ifdef SPI_MASTER_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  assign is_rd  = (cmd_q == 2'b11);
  assign active = (state == START) || (state == SHIFT) ||
                  (state == WAIT_RD) || (state == RECV);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // Next state plus the values SS_n/MOSI take in the next state
  always_comb begin
    next      = state;
    abort_hit = 1'b0;
    ss_d      = 1'b1;
    mosi_d    = 1'b0;
    unique case (state)
      IDLE:    if (start) next = START;
      START:   next = SHIFT;
      SHIFT: begin
        if (bit_cnt == SHIFT_LAST) begin
          if (!is_rd)                  next = STOP;
          else if (RD_TURNAROUND == 0) next = RECV;
          else                         next = WAIT_RD;
        end
      end
      WAIT_RD: if (bit_cnt == WAIT_LAST) next = RECV;
      RECV:    if (bit_cnt == RECV_LAST) next = STOP;
      STOP:    next = IDLE;
      default: next = IDLE;
    endcase
    if (abort_in && active) begin
      next      = STOP;
      abort_hit = 1'b1;
    end
    ss_d = !((next == START) || (next == SHIFT) ||
             (next == WAIT_RD) || (next == RECV));
    if (next == SHIFT) mosi_d = tx_shift[FW-1];
  end

  // Registered link outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS_n <= 1'b1;
      MOSI <= 1'b0;
    end else begin
      SS_n <= ss_d;
      MOSI <= mosi_d;
    end
  end

  // Phase counter, restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               bit_cnt <= '0;
    else if (next != state)   bit_cnt <= '0;
    else if (state != IDLE)   bit_cnt <= bit_cnt + 4'd1;
  end

  // Frame latch and transmit shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= '0;
      tx_shift <= '0;
    end else if (state == IDLE && start) begin
      cmd_q    <= frame_in[FW-1:FW-2];
      tx_shift <= frame_in;
    end else if (state == START || state == SHIFT) begin
      tx_shift <= {tx_shift[FW-2:0], 1'b0};
    end
  end

  // Reply capture; rd_data lands on entry to STOP so it lines up with rd_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      rd_data  <= '0;
    end else if (state == RECV) begin
      rx_shift <= {rx_shift[MEM_WIDTH-3:0], MISO};
      if (next == STOP && !abort_hit)
        rd_data <= {rx_shift, MISO};
    end
  end

  // Remembers whether STOP was reached through an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            aborted <= 1'b0;
    else if (next == STOP) aborted <= abort_hit;
  end

  assign ready    = (state == IDLE);
  assign busy     = ~ready;
  assign done     = (state == STOP) && !aborted;
  assign rd_valid = done && is_rd;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: waveform-timeline model of spi_master_ctrl,
// directed literal checks followed by randomized traffic.
module tb_spi_master_ctrl;

  localparam int MW = 8;
  localparam int TA = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  frame_in = '0;
  logic        MISO = 1'b0;
  logic        ready, busy, done, rd_valid, SS_n, MOSI;
  logic [7:0]  rd_data;
`ifdef SPI_MASTER_ABORT_EN
  logic        abort = 1'b0;
`endif

  always #5 clk = ~clk;

  spi_master_ctrl #(.MEM_WIDTH(MW), .RD_TURNAROUND(TA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_in(frame_in),
    .ready(ready), .busy(busy), .done(done), .rd_data(rd_data),
    .rd_valid(rd_valid), .SS_n(SS_n), .MOSI(MOSI),
`ifdef SPI_MASTER_ABORT_EN
    .abort(abort),
`endif
    .MISO(MISO)
  );

  typedef struct {
    bit         idle;
    bit         ss_n;
    bit         mosi;
    bit         done;
    bit         rdv;
    bit         recv;
    bit         miso;
    bit         stop;
    logic [7:0] rdata;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [7:0] exp_rd;
  logic [7:0] next_reply = '0;
  bit         chk_on = 0;
  int         checks = 0;
  int         errors = 0;

  function automatic exp_t mk(bit i, bit s, bit m);
    exp_t e;
    e.idle = i; e.ss_n = s; e.mosi = m;
    e.done = 0; e.rdv = 0; e.recv = 0;
    e.miso = 0; e.stop = 0; e.rdata = '0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, want);
    end
  endtask

  // Model: each accepted frame expands into its cycle-by-cycle waveform
  logic [9:0] mf;
  logic [7:0] mr;
  exp_t       me;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur    = mk(1, 1, 0);
      exp_rd = '0;
    end else begin
`ifdef SPI_MASTER_ABORT_EN
      if (abort && !cur.idle && !cur.stop) begin
        q.delete();
        me = mk(0, 1, 0);
        me.stop = 1;
        q.push_back(me);
      end
`endif
      if (cur.idle && start) begin
        mf = frame_in;
        mr = next_reply;
        q.push_back(mk(0, 0, 0));
        for (int i = 0; i < MW + 2; i++) begin
          q.push_back(mk(0, 0, mf[9]));
          mf = {mf[8:0], 1'b0};
        end
        if (frame_in[9:8] == 2'b11) begin
          for (int i = 0; i < TA; i++) q.push_back(mk(0, 0, 0));
          for (int i = 0; i < MW; i++) begin
            me = mk(0, 0, 0);
            me.recv = 1;
            me.miso = mr[7];
            mr = {mr[6:0], 1'b0};
            q.push_back(me);
          end
        end
        me = mk(0, 1, 0);
        me.done  = 1;
        me.stop  = 1;
        me.rdv   = (frame_in[9:8] == 2'b11);
        me.rdata = next_reply;
        q.push_back(me);
      end
      if (q.size() > 0) cur = q.pop_front();
      else              cur = mk(1, 1, 0);
      if (cur.rdv) exp_rd = cur.rdata;
    end
  end

  // Slave stand-in: reply bits in RECV, noise everywhere else
  always @(posedge clk) begin
    #1;
    MISO = cur.recv ? cur.miso : 1'($urandom);
  end

  // Compare process
  always @(negedge clk) begin
    if (chk_on) begin
      chk("SS_n", 32'(SS_n), 32'(cur.ss_n));
      chk("MOSI", 32'(MOSI), 32'(cur.mosi));
      chk("ready", 32'(ready), 32'(cur.idle));
      chk("busy", 32'(busy), 32'(!cur.idle));
      chk("done", 32'(done), 32'(cur.done));
      chk("rd_valid", 32'(rd_valid), 32'(cur.rdv));
      chk("rd_data", 32'(rd_data), 32'(exp_rd));
    end
  end

  task automatic xfer(input logic [9:0] f, input logic [7:0] rep,
                      input int inj, output int bn, output int sl,
                      output logic [9:0] mb, output int dn,
                      output int rv, output int dcyc);
    bn = 0; sl = 0; mb = '0; dn = 0; rv = 0; dcyc = 0;
    next_reply = rep;
    frame_in = f;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    frame_in = f ^ 10'h155;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
      bn++;
      if (!SS_n) begin
        sl++;
        if (sl >= 2 && sl <= 11) mb = {mb[8:0], MOSI};
      end
      if (done) begin dn++; dcyc = bn; end
      if (rd_valid) rv++;
      if (bn == inj) begin start = 1; frame_in = 10'h3FF; end
      if (bn == inj + 1) start = 0;
    end
    chk("xfer_end_idle", 32'(busy), 32'd0);
  endtask

  int         bn, sl, dn, rv, dcyc, ph, gap;
  logic [9:0] mb;

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    chk_on = 1;
    @(posedge clk);
    #1;
    chk("rst_SS_n", 32'(SS_n), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // write address frame
    xfer(10'b00_1010_0101, 8'h00, -1, bn, sl, mb, dn, rv, dcyc);
    chk("wa_busy", 32'(bn), 32'd12);
    chk("wa_ss_low", 32'(sl), 32'd11);
    chk("wa_mosi", 32'(mb), 32'b0010100101);
    chk("wa_done_cnt", 32'(dn), 32'd1);
    chk("wa_done_cyc", 32'(dcyc), 32'd12);
    chk("wa_rd_valid", 32'(rv), 32'd0);
    @(posedge clk);
    #1;

    // read data frame with reply C3
    xfer(10'b11_0000_0000, 8'hC3, -1, bn, sl, mb, dn, rv, dcyc);
    chk("rd_busy", 32'(bn), 32'd22);
    chk("rd_ss_low", 32'(sl), 32'd21);
    chk("rd_done_cnt", 32'(dn), 32'd1);
    chk("rd_valid_cnt", 32'(rv), 32'd1);
    chk("rd_data_c3", 32'(rd_data), 32'hC3);
    @(posedge clk);
    #1;

    // start while busy at SHIFT bit 3
    xfer(10'b01_0110_1100, 8'h00, 5, bn, sl, mb, dn, rv, dcyc);
    chk("sb_mosi", 32'(mb), 32'b0101101100);
    chk("sb_done_cnt", 32'(dn), 32'd1);
    chk("sb_busy", 32'(bn), 32'd12);
    @(posedge clk);
    #1;

    // back-to-back with start held high
    ph = 0; gap = 0;
    frame_in = 10'b01_1100_0011;
    start = 1;
    for (int c = 0; c < 60 && ph < 3; c++) begin
      @(negedge clk);
      if (c == 3) frame_in = 10'b01_0011_1100;
      case (ph)
        0: if (!SS_n) ph = 1;
        1: if (SS_n) begin ph = 2; gap = 1; end
        2: if (SS_n) gap++; else ph = 3;
        default: ;
      endcase
    end
    start = 0;
    chk("b2b_second", 32'(ph), 32'd3);
    chk("b2b_gap", 32'(gap), 32'd2);
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

`ifdef SPI_MASTER_ABORT_EN
    // abort in RECV bit 5; rd_data keeps C3
    next_reply = 8'h5A;
    frame_in = 10'b11_0000_0000;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (19) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("ab_SS_n", 32'(SS_n), 32'd1);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_rd_valid", 32'(rd_valid), 32'd0);
    chk("ab_rd_data", 32'(rd_data), 32'hC3);
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    chk("ab_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
`endif

    // reset during SHIFT bit 4 after a read left rd_data nonzero
    xfer(10'b11_0000_0000, 8'hC3, -1, bn, sl, mb, dn, rv, dcyc);
    @(posedge clk);
    #1;
    frame_in = 10'b10_0110_1001;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("mr_SS_n", 32'(SS_n), 32'd1);
    chk("mr_MOSI", 32'(MOSI), 32'd0);
    chk("mr_ready", 32'(ready), 32'd1);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      frame_in = 10'($urandom);
      next_reply = 8'($urandom);
`ifdef SPI_MASTER_ABORT_EN
      abort = ($urandom_range(0, 40) == 0);
`endif
      @(posedge clk);
      #1;
    end
    start = 0;
`ifdef SPI_MASTER_ABORT_EN
    abort = 0;
`endif
    for (int c = 0; c < 40 && busy; c++) @(negedge clk);
    chk("rand_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
